uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_fifo.sv | 50 +++++
 rtl/uart_tx.sv | 117 +++++++++++
 tb/tb_uart_tx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and transmitter state encoding
package uart_pkg;

  localparam int DATA_BITS_DEF  = 8;
  localparam int STOP_BITS_DEF  = 1;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t ST_IDLE   = 3'd0;
  localparam tx_state_t ST_START  = 3'd1;
  localparam tx_state_t ST_DATA   = 3'd2;
  localparam tx_state_t ST_PARITY = 3'd3;
  localparam tx_state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - count-based synchronous FIFO used as the transmit buffer
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - buffered UART transmitter advanced by an external baud tick
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = STOP_BITS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int BW = $clog2(DATA_BITS) + 1;

  tx_state_t            state;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bit_cnt;
  logic [1:0]           stop_cnt;
  logic                 par_bit;
  logic                 tx_q;
  logic                 ready_en;
  logic [DATA_BITS-1:0] head;
  logic                 full;
  logic                 empty;
  logic                 last_stop;
  logic                 start_ok;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid && in_ready),
    .push_data (in_data),
    .pop       (start_ok),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // ready_en keeps in_ready low through reset and the cycle it is released.
  assign in_ready  = ready_en && !full;
  assign busy      = (state != ST_IDLE) || !empty;
  assign tx        = tx_q;
  assign last_stop = (state == ST_STOP) && (stop_cnt == 2'(STOP_BITS));
  assign start_ok  = tick && !empty && ((state == ST_IDLE) || last_stop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
      par_bit  <= 1'b0;
      tx_q     <= 1'b1;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (start_ok) begin
        shreg   <= head;
        par_bit <= (^head) ^ (PARITY_ODD != 0);
        tx_q    <= 1'b0;
        state   <= ST_START;
      end else if (tick) begin
        case (state)
          ST_IDLE: tx_q <= 1'b1;
          ST_START: begin
            tx_q    <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= BW'(1);
            state   <= ST_DATA;
          end
          ST_DATA: begin
            if (bit_cnt == BW'(DATA_BITS)) begin
              if (PARITY_EN != 0) begin
                tx_q  <= par_bit;
                state <= ST_PARITY;
              end else begin
                tx_q     <= 1'b1;
                stop_cnt <= 2'd1;
                state    <= ST_STOP;
              end
            end else begin
              tx_q    <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
          ST_PARITY: begin
            tx_q     <= 1'b1;
            stop_cnt <= 2'd1;
            state    <= ST_STOP;
          end
          ST_STOP: begin
            tx_q <= 1'b1;
            if (last_stop) state <= ST_IDLE;
            else           stop_cnt <= stop_cnt + 2'd1;
          end
          default: begin
            tx_q  <= 1'b1;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed table-driven bench for uart_tx with four parameter sets
module tb_uart_tx;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick  = 1'b0;
  int         tcnt  = 0;
  logic [7:0] in_data_r  [4];
  logic       in_valid_r [4];
  logic       in_ready_w [4];
  logic       tx_w       [4];
  logic       busy_w     [4];
  int         tests = 0;
  int         fails = 0;

  typedef struct {
    int          sel;
    logic [7:0]  data;
    int          nbits;
    logic [11:0] exp;
    string       name;
  } vec_t;

  vec_t vt [9];

  always #5 clk = ~clk;

  // Baud strobe: one clk-wide pulse every 20 clk.
  initial begin
    forever begin
      @(negedge clk);
      tick = (tcnt == 19);
      tcnt = (tcnt == 19) ? 0 : tcnt + 1;
    end
  end

  uart_tx u_def (
    .clk(clk), .rst_n(rst_n), .tick(tick), .in_data(in_data_r[0]), .in_valid(in_valid_r[0]),
    .in_ready(in_ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0])
  );
  uart_tx #(.PARITY_EN(1)) u_pe (
    .clk(clk), .rst_n(rst_n), .tick(tick), .in_data(in_data_r[1]), .in_valid(in_valid_r[1]),
    .in_ready(in_ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1])
  );
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u_po (
    .clk(clk), .rst_n(rst_n), .tick(tick), .in_data(in_data_r[2]), .in_valid(in_valid_r[2]),
    .in_ready(in_ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2])
  );
  uart_tx #(.STOP_BITS(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .in_data(in_data_r[3]), .in_valid(in_valid_r[3]),
    .in_ready(in_ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int s, input logic [7:0] d, output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    in_data_r[s]  = d;
    in_valid_r[s] = 1'b1;
    while (!ok && waited < 2000) begin
      if (in_ready_w[s] === 1'b1) ok = 1'b1;
      else begin
        @(negedge clk);
        waited++;
      end
    end
    @(negedge clk);
    in_valid_r[s] = 1'b0;
  endtask

  task automatic push_chk(input int s, input logic [7:0] d, input string name);
    bit ok;
    int waited;
    push(s, d, ok, waited);
    check({name, " accepted"}, 32'(ok), 32'd1);
  endtask

  task automatic align_tick();
    int n = 0;
    while (tick !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  // Checks every clk of a frame against the expected bit for that 20-clk slot.
  task automatic capture(input int s, input int nbits, input logic [11:0] exp,
                         input bit immediate, input bit idle_after, input string name);
    int          waitc = 0;
    logic [11:0] obs = '0;
    bit          exact = 1'b1;
    logic        busy_last = 1'b0;
    while (tx_w[s] !== 1'b0 && waitc < 3000) begin
      @(negedge clk);
      waitc++;
    end
    check({name, " start seen"}, 32'(tx_w[s]), 32'd0);
    if (tx_w[s] !== 1'b0) return;
    if (immediate) check({name, " contiguous"}, 32'(waitc), 32'd0);
    for (int c = 0; c < nbits * 20; c++) begin
      if (tx_w[s] !== exp[c / 20]) exact = 1'b0;
      if (c % 20 == 10) obs[c / 20] = tx_w[s];
      if (c == nbits * 20 - 1) busy_last = busy_w[s];
      @(negedge clk);
    end
    check({name, " bits"}, 32'(obs), 32'(exp));
    check({name, " bit timing"}, 32'(exact), 32'd1);
    check({name, " busy in last stop"}, 32'(busy_last), 32'd1);
    if (idle_after) begin
      check({name, " busy after"}, 32'(busy_w[s]), 32'd0);
      check({name, " tx idle after"}, 32'(tx_w[s]), 32'd1);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int          waited;
    int          n;
    bit          quiet;
    logic [7:0]  kb;
    logic [11:0] e;

    for (int s = 0; s < 4; s++) begin
      in_data_r[s]  = 8'h00;
      in_valid_r[s] = 1'b0;
    end

    vt[0] = '{0, 8'hA5, 10, {2'b00, 1'b1, 8'hA5, 1'b0}, "def_a5"};
    vt[1] = '{0, 8'h00, 10, {2'b00, 1'b1, 8'h00, 1'b0}, "def_00"};
    vt[2] = '{0, 8'hFF, 10, {2'b00, 1'b1, 8'hFF, 1'b0}, "def_ff"};
    vt[3] = '{0, 8'h3C, 10, {2'b00, 1'b1, 8'h3C, 1'b0}, "def_3c"};
    vt[4] = '{1, 8'h07, 11, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, "even_07"};
    vt[5] = '{1, 8'h03, 11, {1'b0, 1'b1, 1'b0, 8'h03, 1'b0}, "even_03"};
    vt[6] = '{2, 8'h07, 11, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, "odd_07"};
    vt[7] = '{2, 8'h00, 11, {1'b0, 1'b1, 1'b1, 8'h00, 1'b0}, "odd_00"};
    vt[8] = '{3, 8'h81, 11, {1'b0, 1'b1, 1'b1, 8'h81, 1'b0}, "stop2_81"};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      check($sformatf("reset tx[%0d]", s), 32'(tx_w[s]), 32'd1);
      check($sformatf("reset busy[%0d]", s), 32'(busy_w[s]), 32'd0);
      check($sformatf("reset in_ready[%0d]", s), 32'(in_ready_w[s]), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    check("in_ready before first edge", 32'(in_ready_w[0]), 32'd0);
    @(negedge clk);
    check("in_ready after first edge", 32'(in_ready_w[0]), 32'd1);

    for (int i = 0; i < 9; i++) begin
      push_chk(vt[i].sel, vt[i].data, vt[i].name);
      capture(vt[i].sel, vt[i].nbits, vt[i].exp, 1'b0, 1'b1, vt[i].name);
    end

    // Five back-to-back bytes into a four-entry buffer.
    align_tick();
    fork
      begin
        for (int k = 1; k <= 5; k++) begin
          push(0, 8'(k), ok, waited);
          check($sformatf("burst push %0d accepted", k), 32'(ok), 32'd1);
          if (k == 4) check("burst in_ready when full", 32'(in_ready_w[0]), 32'd0);
          if (k == 5) check("burst 5th held", 32'(waited > 0), 32'd1);
        end
      end
      begin
        for (int k = 1; k <= 5; k++) begin
          kb = 8'(k);
          e = {2'b00, 1'b1, kb, 1'b0};
          capture(0, 10, e, k > 1, k == 5, $sformatf("burst frame %0d", k));
        end
      end
    join

    // Two stop bits between back-to-back frames.
    align_tick();
    push_chk(3, 8'h00, "stop2 byte1");
    push_chk(3, 8'hFF, "stop2 byte2");
    capture(3, 11, {1'b0, 1'b1, 1'b1, 8'h00, 1'b0}, 1'b0, 1'b0, "stop2 frame1");
    capture(3, 11, {1'b0, 1'b1, 1'b1, 8'hFF, 1'b0}, 1'b1, 1'b1, "stop2 frame2");

    // Reset during data bit 3 with a second byte still buffered.
    align_tick();
    push_chk(0, 8'hA5, "rst byte1");
    push_chk(0, 8'h5A, "rst byte2");
    n = 0;
    while (tx_w[0] !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst frame started", 32'(tx_w[0]), 32'd0);
    repeat (85) @(negedge clk);
    check("rst busy before reset", 32'(busy_w[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst tx immediate", 32'(tx_w[0]), 32'd1);
    check("rst busy immediate", 32'(busy_w[0]), 32'd0);
    repeat (5) @(negedge clk);
    check("rst in_ready held low", 32'(in_ready_w[0]), 32'd0);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) quiet = 1'b0;
    end
    check("rst no residual frame", 32'(quiet), 32'd1);
    push_chk(0, 8'h3C, "post-rst byte");
    capture(0, 10, {2'b00, 1'b1, 8'h3C, 1'b0}, 1'b0, 1'b1, "post-rst frame");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
